// File: rtl/ysyx_22040237_lsu.sv
// ============================================================================
// Module   : ysyx_22040237_lsu
// Brief    : Load/store unit between EXU and WBU; one aligned 64-bit memory
//            request per memory instruction, load extension, store byte mask.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ysyx_22040237_lsu #(
  parameter int REG_WIDTH  = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  mem_rd_en_i,
  input  logic                  mem_wr_en_i,
  input  logic [2:0]            funct3_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [REG_WIDTH-1:0]  wdata_i,
  input  logic [REG_WIDTH-1:0]  alu_data_i,
  input  logic                  rd_wr_en_i,
  input  logic [4:0]            rd_idx_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_we_o,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  output logic [REG_WIDTH-1:0]  mem_req_wdata_o,
  output logic [7:0]            mem_req_wmask_o,
  input  logic                  mem_resp_valid_i,
  input  logic [REG_WIDTH-1:0]  mem_resp_rdata_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  rd_wr_en_o,
  output logic [4:0]            rd_idx_o,
  output logic [REG_WIDTH-1:0]  rd_data_o,
  output logic                  lsu_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state, w_state_nxt;

  logic                  r_we;
  logic [2:0]            r_funct3;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [REG_WIDTH-1:0]  r_wdata;
  logic [4:0]            r_rd_idx;
  logic                  r_rd_wr_en;
  logic [REG_WIDTH-1:0]  r_rd_data;
  logic                  r_err;

  logic                  w_is_mem;
  logic                  w_illegal;
  logic                  w_misalign;
  logic                  w_bad;
  logic                  w_accept;
  logic [2:0]            w_off;
  logic [7:0]            w_size_mask;
  logic [REG_WIDTH-1:0]  w_shifted;
  logic [REG_WIDTH-1:0]  w_load_data;

  // Decode of the incoming instruction, evaluated only while accepting
  assign w_is_mem  = mem_rd_en_i | mem_wr_en_i;
  assign w_illegal = mem_rd_en_i ? (funct3_i == 3'b111) : (mem_wr_en_i & funct3_i[2]);
  assign w_bad     = w_is_mem & (w_illegal | w_misalign);
  assign w_accept  = (r_state == S_IDLE) & in_valid_i;

  always_comb begin
    w_misalign = 1'b0;
    case (funct3_i[1:0])
      2'b01:   w_misalign = addr_i[0];
      2'b10:   w_misalign = |addr_i[1:0];
      2'b11:   w_misalign = |addr_i[2:0];
      default: w_misalign = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (in_valid_i) w_state_nxt = (!w_is_mem || w_bad) ? S_DONE : S_REQ;
      S_REQ:  if (mem_req_ready_i) w_state_nxt = S_WAIT;
      S_WAIT: if (mem_resp_valid_i) w_state_nxt = S_DONE;
      S_DONE: if (out_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready_o      = (r_state == S_IDLE);
  assign mem_req_valid_o = (r_state == S_REQ);
  assign out_valid_o     = (r_state == S_DONE);

  // Request fields derive only from captured state, so they hold during stalls
  assign w_off = r_addr[2:0];

  always_comb begin
    w_size_mask = 8'h01;
    case (r_funct3[1:0])
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  assign mem_req_we_o    = r_we;
  assign mem_req_addr_o  = {r_addr[ADDR_WIDTH-1:3], 3'b000};
  assign mem_req_wdata_o = r_wdata << {w_off, 3'b000};
  assign mem_req_wmask_o = r_we ? (w_size_mask << w_off) : 8'h00;

  assign w_shifted = mem_resp_rdata_i >> {w_off, 3'b000};

  always_comb begin
    w_load_data = w_shifted;
    case (r_funct3)
      3'b000:  w_load_data = {{(REG_WIDTH-8){w_shifted[7]}},   w_shifted[7:0]};
      3'b001:  w_load_data = {{(REG_WIDTH-16){w_shifted[15]}}, w_shifted[15:0]};
      3'b010:  w_load_data = {{(REG_WIDTH-32){w_shifted[31]}}, w_shifted[31:0]};
      3'b100:  w_load_data = {{(REG_WIDTH-8){1'b0}},  w_shifted[7:0]};
      3'b101:  w_load_data = {{(REG_WIDTH-16){1'b0}}, w_shifted[15:0]};
      3'b110:  w_load_data = {{(REG_WIDTH-32){1'b0}}, w_shifted[31:0]};
      default: w_load_data = w_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we       <= 1'b0;
      r_funct3   <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_idx   <= 5'd0;
      r_rd_wr_en <= 1'b0;
      r_rd_data  <= '0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_we     <= mem_wr_en_i;
      r_funct3 <= funct3_i;
      r_addr   <= addr_i;
      r_wdata  <= wdata_i;
      r_rd_idx <= rd_idx_i;
      if (!w_is_mem) begin
        r_rd_data  <= alu_data_i;
        r_rd_wr_en <= rd_wr_en_i;
        r_err      <= 1'b0;
      end else if (w_bad) begin
        r_rd_data  <= '0;
        r_rd_wr_en <= 1'b0;
        r_err      <= 1'b1;
      end else begin
        r_rd_data  <= '0;
        r_rd_wr_en <= rd_wr_en_i & ~mem_wr_en_i;
        r_err      <= 1'b0;
      end
    end else if ((r_state == S_WAIT) && mem_resp_valid_i) begin
      r_rd_data <= r_we ? '0 : w_load_data;
      if (r_we) r_rd_wr_en <= 1'b0;
    end
  end

  assign rd_wr_en_o = r_rd_wr_en;
  assign rd_idx_o   = r_rd_idx;
  assign rd_data_o  = r_rd_data;
  assign lsu_err_o  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_22040237_lsu.sv
// Testbench for ysyx_22040237_lsu: scoreboard of expected requests/results
// built from a byte-level reference model, with memory and WBU backpressure.
`default_nettype none

module tb_ysyx_22040237_lsu;

  logic        clk, rst;
  logic        in_valid_i, in_ready_o;
  logic        mem_rd_en_i, mem_wr_en_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i, wdata_i, alu_data_i;
  logic        rd_wr_en_i;
  logic [4:0]  rd_idx_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
  logic [63:0] mem_req_addr_o, mem_req_wdata_o;
  logic [7:0]  mem_req_wmask_o;
  logic        mem_resp_valid_i;
  logic [63:0] mem_resp_rdata_i;
  logic        out_valid_o, out_ready_i, rd_wr_en_o, lsu_err_o;
  logic [4:0]  rd_idx_o;
  logic [63:0] rd_data_o;

  ysyx_22040237_lsu #(.REG_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .mem_rd_en_i(mem_rd_en_i), .mem_wr_en_i(mem_wr_en_i),
    .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .alu_data_i(alu_data_i), .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_req_wmask_o(mem_req_wmask_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_rdata_i(mem_resp_rdata_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .rd_wr_en_o(rd_wr_en_o), .rd_idx_o(rd_idx_o), .rd_data_o(rd_data_o),
    .lsu_err_o(lsu_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr_en;
    logic [4:0]  idx;
    logic [63:0] data;
    logic        err;
    logic        chk_data;
  } out_exp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  mask;
    logic        we;
  } req_exp_t;

  out_exp_t out_q[$];
  req_exp_t req_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-wise placement and extension
  task automatic build_exp(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [63:0] addr, input logic [63:0] wd,
                           input logic [63:0] alu, input logic rdwe,
                           input logic [4:0] idx, input logic [63:0] rdata,
                           output out_exp_t oe, output req_exp_t re, output logic has_req);
    int nbytes, off;
    logic legal, aligned;
    logic [63:0] val;
    nbytes  = 1 << f3[1:0];
    off     = int'(addr[2:0]);
    legal   = rd ? (f3 != 3'd7) : (f3 < 3'd4);
    aligned = ((addr % 64'(nbytes)) == 64'd0);
    re      = '0;
    oe      = '0;
    oe.idx  = idx;
    has_req = 1'b0;
    if (!(rd | wr)) begin
      oe.wr_en = rdwe; oe.data = alu; oe.chk_data = 1'b1;
    end else if (!legal || !aligned) begin
      oe.err = 1'b1;
    end else begin
      has_req  = 1'b1;
      re.addr  = addr & ~64'h7;
      re.we    = wr;
      re.wdata = wd << (8 * off);
      val      = '0;
      for (int i = 0; i < nbytes; i++) begin
        if (wr) re.mask[off + i] = 1'b1;
        val[8*i +: 8] = rdata[8*(off + i) +: 8];
      end
      for (int b = nbytes * 8; b < 64; b++)
        val[b] = f3[2] ? 1'b0 : val[nbytes*8 - 1];
      oe.wr_en    = wr ? 1'b0 : rdwe;
      oe.data     = wr ? 64'd0 : val;
      oe.chk_data = 1'b1;
    end
  endtask

  task automatic run_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [63:0] alu,
                        input logic rdwe, input logic [4:0] idx, input logic [63:0] rdata,
                        input int req_stall, input int out_stall);
    out_exp_t oe, og;
    req_exp_t re, rg, rcap;
    logic has_req, done, out_seen, req_seen, hs, stable;
    int cyc, lat, nreq, rs, os, lat_exp;
    logic [63:0] cap_data;
    logic        cap_en, cap_err;
    logic [4:0]  cap_idx;
    build_exp(rd, wr, f3, addr, wd, alu, rdwe, idx, rdata, oe, re, has_req);
    out_q.push_back(oe);
    if (has_req) req_q.push_back(re);
    lat_exp = has_req ? 3 + req_stall : 1;
    done = 0; out_seen = 0; req_seen = 0; hs = 0; stable = 1;
    lat = 0; nreq = 0; rs = 0; os = 0;
    rcap = '0; cap_data = '0; cap_en = 0; cap_err = 0; cap_idx = '0;

    @(negedge clk);
    check({"in_ready_", nm}, in_ready_o, 1'b1);
    in_valid_i = 1; mem_rd_en_i = rd; mem_wr_en_i = wr; funct3_i = f3;
    addr_i = addr; wdata_i = wd; alu_data_i = alu; rd_wr_en_i = rdwe; rd_idx_i = idx;
    @(negedge clk);
    in_valid_i = 0; mem_rd_en_i = 0; mem_wr_en_i = 0;
    cyc = 1;
    while (!done && cyc < 40) begin
      mem_resp_valid_i = 0;
      if (hs) begin
        mem_resp_valid_i = 1; mem_resp_rdata_i = rdata; hs = 0;
      end
      if (mem_req_valid_o) begin
        rg = {mem_req_addr_o, mem_req_wdata_o, mem_req_wmask_o, mem_req_we_o};
        if (!req_seen) begin
          req_seen = 1; rcap = rg;
          if (req_q.size() == 0) check({"req_unexpected_", nm}, 1'b1, 1'b0);
          else begin
            re = req_q.pop_front();
            check({"req_addr_", nm},  rg.addr,  re.addr);
            check({"req_wdata_", nm}, rg.wdata, re.wdata);
            check({"req_mask_", nm},  rg.mask,  re.mask);
            check({"req_we_", nm},    rg.we,    re.we);
          end
        end else if (rg !== rcap) stable = 0;
        if (rs >= req_stall) begin mem_req_ready_i = 1; hs = 1; nreq++; end
        else mem_req_ready_i = 0;
        rs++;
      end else mem_req_ready_i = 0;
      if (out_valid_o) begin
        if (!out_seen) begin
          out_seen = 1; lat = cyc;
          cap_data = rd_data_o; cap_en = rd_wr_en_o; cap_err = lsu_err_o; cap_idx = rd_idx_o;
          og = out_q.pop_front();
          check({"rd_wr_en_", nm}, rd_wr_en_o, og.wr_en);
          check({"rd_idx_", nm},   rd_idx_o,   og.idx);
          check({"lsu_err_", nm},  lsu_err_o,  og.err);
          if (og.chk_data) check({"rd_data_", nm}, rd_data_o, og.data);
        end else if (rd_data_o !== cap_data || rd_wr_en_o !== cap_en ||
                     lsu_err_o !== cap_err || rd_idx_o !== cap_idx) stable = 0;
        if (os >= out_stall) begin out_ready_i = 1; done = 1; end
        else out_ready_i = 0;
        os++;
      end else out_ready_i = 0;
      @(negedge clk);
      cyc++;
    end
    out_ready_i = 0; mem_req_ready_i = 0; mem_resp_valid_i = 0;
    if (!done) begin
      check({"timeout_", nm}, 1'b0, 1'b1);
      out_q.delete(); req_q.delete();
    end
    check({"latency_", nm},  64'(lat),  64'(lat_exp));
    check({"nreq_", nm},     64'(nreq), has_req ? 64'd1 : 64'd0);
    check({"stable_", nm},   stable,    1'b1);
    check({"idle_after_", nm}, {in_ready_o, out_valid_o, mem_req_valid_o}, 3'b100);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    in_valid_i = 0; mem_rd_en_i = 0; mem_wr_en_i = 0; funct3_i = 0;
    addr_i = 0; wdata_i = 0; alu_data_i = 0; rd_wr_en_i = 0; rd_idx_i = 0;
    mem_req_ready_i = 0; mem_resp_valid_i = 0; mem_resp_rdata_i = 0; out_ready_i = 0;
    @(negedge clk); @(negedge clk);
    check("rst_in_ready", in_ready_o, 1'b1);
    check("rst_valids", {mem_req_valid_o, out_valid_o}, 2'b00);
    check("rst_out_fields", {rd_wr_en_o, lsu_err_o, rd_idx_o, rd_data_o}, 71'd0);
    rst = 1;

    //      name       rd wr f3      addr            wdata           alu        rdwe idx rdata                    rqs ous
    run_op("nonmem",   0, 0, 3'b000, 64'h0,          64'h0,          64'h1234,  1, 5,  64'h0,                   0, 0);
    run_op("nonmem_nw",0, 0, 3'b011, 64'h3,          64'h0,          64'hCAFE,  0, 9,  64'h0,                   0, 0);
    run_op("lb",       1, 0, 3'b000, 64'h80000003,   64'h0,          64'h0,     1, 7,  64'h00000000_80000000,   0, 0);
    run_op("lbu",      1, 0, 3'b100, 64'h80000003,   64'h0,          64'h0,     1, 7,  64'h00000000_80000000,   0, 0);
    run_op("sh",       0, 1, 3'b001, 64'h80000006,   64'hBEEF,       64'h0,     1, 3,  64'h0,                   0, 0);
    run_op("lw_mis",   1, 0, 3'b010, 64'h80000002,   64'h0,          64'h0,     1, 4,  64'h0,                   0, 0);
    run_op("ld_bp",    1, 0, 3'b011, 64'h80000008,   64'h0,          64'h0,     1, 10, 64'h01234567_89ABCDEF,   3, 2);
    run_op("lh",       1, 0, 3'b001, 64'h80000012,   64'h0,          64'h0,     1, 11, 64'hAAAA_BBBB_8001_CCCC, 1, 0);
    run_op("lhu",      1, 0, 3'b101, 64'h80000012,   64'h0,          64'h0,     1, 11, 64'hAAAA_BBBB_8001_CCCC, 0, 1);
    run_op("lwu",      1, 0, 3'b110, 64'h80000004,   64'h0,          64'h0,     1, 12, 64'hF00D_F00D_0000_0000, 0, 0);
    run_op("lw",       1, 0, 3'b010, 64'h80000004,   64'h0,          64'h0,     1, 12, 64'hF00D_F00D_0000_0000, 0, 0);
    run_op("sb",       0, 1, 3'b000, 64'h80000005,   64'h12345678_9A,64'h0,     1, 1,  64'h0,                   2, 0);
    run_op("sd",       0, 1, 3'b011, 64'h80000010,   64'hDEADBEEF_0BADF00D, 64'h0, 1, 2, 64'h0,                 0, 0);
    run_op("ld_illf3", 1, 0, 3'b111, 64'h80000000,   64'h0,          64'h0,     1, 6,  64'h0,                   0, 0);
    run_op("sd_illf3", 0, 1, 3'b100, 64'h80000000,   64'h55,         64'h0,     1, 6,  64'h0,                   0, 0);
    run_op("sw_mis",   0, 1, 3'b010, 64'h80000001,   64'h55,         64'h0,     1, 6,  64'h0,                   0, 1);

    // Reset while waiting on the response; a late response must be dropped
    @(negedge clk);
    in_valid_i = 1; mem_rd_en_i = 1; funct3_i = 3'b011; addr_i = 64'h80000020;
    rd_wr_en_i = 1; rd_idx_i = 8;
    @(negedge clk);
    in_valid_i = 0; mem_rd_en_i = 0;
    check("rstw_in_req", mem_req_valid_o, 1'b1);
    mem_req_ready_i = 1;
    @(negedge clk);
    mem_req_ready_i = 0;
    check("rstw_in_wait", {in_ready_o, mem_req_valid_o, out_valid_o}, 3'b000);
    rst = 0;
    #1;
    check("rstw_async_idle", {in_ready_o, mem_req_valid_o, out_valid_o}, 3'b100);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    mem_resp_valid_i = 1; mem_resp_rdata_i = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    mem_resp_valid_i = 0;
    check("rstw_late_resp", {in_ready_o, out_valid_o}, 2'b10);
    @(negedge clk);
    check("rstw_still_idle", {in_ready_o, out_valid_o, mem_req_valid_o}, 3'b100);

    run_op("post_rst", 0, 0, 3'b000, 64'h0, 64'h0, 64'h77, 1, 31, 64'h0, 0, 0);

    check("queues_empty", 64'(out_q.size() + req_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
